// File: rtl/cpu_nios_oci_dct_packer.sv
// rtl/cpu_nios_oci_dct_packer.sv - packs 2-bit trace atoms into frames
//
// Purpose: accumulates 2-bit OCI trace atoms into 2*ATOMS-bit frames. Each
// frame goes out through a one-deep holding register with a valid/ready
// handshake. An end-of-test drain sequence flushes the last partial frame.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   atom_valid/atom   atom offered; atom_ready accepts it (state only)
//   flush             close current partial frame (pulse)
//   test_end          start end-of-test drain (pulse)
//   dct_buffer        frame, atom k at bits [2k+1:2k], unused bits 0
//   dct_count         atoms in frame; 0 while out_valid is low
//   out_valid/ready   frame handshake
//   test_ending       high during drain
//   test_has_ended    high once drained; sticky until reset
module cpu_nios_oci_dct_packer #(
  parameter int ATOMS = 15,
  localparam int BW = 2 * ATOMS,
  localparam int CW = $clog2(ATOMS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          atom_valid,
  input  logic [1:0]    atom,
  output logic          atom_ready,
  input  logic          flush,
  input  logic          test_end,
  output logic [BW-1:0] dct_buffer,
  output logic [CW-1:0] dct_count,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          test_ending,
  output logic          test_has_ended
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_ENDED = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] acc_q, acc_d;
  logic [CW-1:0] acc_cnt_q, acc_cnt_d;
  logic          flush_pend_q, flush_pend_d;
  logic [BW-1:0] hold_buf_q, hold_buf_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic          out_valid_q, out_valid_d;

  logic          accept;
  logic          hold_free;
  logic          flush_in;
  logic          transfer;
  logic [CW-1:0] next_cnt;
  logic [BW-1:0] acc_ins;

  // Readiness depends only on state so a producer can never be stalled by its
  // own valid; it is forced low while reset is held so every output reads 0.
  assign atom_ready = !reset && (state_q == ST_RUN) && (acc_cnt_q < CW'(ATOMS));
  assign accept     = atom_valid && atom_ready;
  assign hold_free  = !out_valid_q || out_ready;
  assign flush_in   = flush && (state_q != ST_ENDED);
  assign next_cnt   = acc_cnt_q + CW'(accept);

  // Slots above acc_cnt are always zero, so OR-ing the shifted atom in is
  // equivalent to a slot write.
  assign acc_ins = accept ? (acc_q | (BW'(atom) << {acc_cnt_q, 1'b0})) : acc_q;

  assign transfer = hold_free && (next_cnt != '0) &&
                    ((next_cnt == CW'(ATOMS)) || flush_in || flush_pend_q ||
                     (state_q == ST_DRAIN));

  always_comb begin
    acc_d        = acc_ins;
    acc_cnt_d    = next_cnt;
    flush_pend_d = flush_pend_q;
    hold_buf_d   = hold_buf_q;
    hold_cnt_d   = hold_cnt_q;
    out_valid_d  = out_valid_q;

    if (transfer) begin
      hold_buf_d   = acc_ins;
      hold_cnt_d   = next_cnt;
      out_valid_d  = 1'b1;
      acc_d        = '0;
      acc_cnt_d    = '0;
      flush_pend_d = 1'b0;
    end else begin
      // Flush against a busy holding register is remembered; an empty flush is not.
      if (flush_in && (next_cnt != '0)) begin
        flush_pend_d = 1'b1;
      end
      if (out_valid_q && out_ready) begin
        hold_buf_d  = '0;
        hold_cnt_d  = '0;
        out_valid_d = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (test_end) state_d = ST_DRAIN;
      ST_DRAIN: if ((acc_cnt_q == '0) && hold_free) state_d = ST_ENDED;
      ST_ENDED: state_d = ST_ENDED;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RUN;
      acc_q        <= '0;
      acc_cnt_q    <= '0;
      flush_pend_q <= 1'b0;
      hold_buf_q   <= '0;
      hold_cnt_q   <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      acc_cnt_q    <= acc_cnt_d;
      flush_pend_q <= flush_pend_d;
      hold_buf_q   <= hold_buf_d;
      hold_cnt_q   <= hold_cnt_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign dct_buffer     = hold_buf_q;
  assign dct_count      = hold_cnt_q;
  assign out_valid      = out_valid_q;
  assign test_ending    = (state_q == ST_DRAIN);
  assign test_has_ended = (state_q == ST_ENDED);

endmodule

// File: tb/tb_cpu_nios_oci_dct_packer.sv
// tb/tb_cpu_nios_oci_dct_packer.sv - directed self-checking bench for the atom packer
module tb_cpu_nios_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        atom_valid;
  logic [1:0]  atom;
  logic        atom_ready;
  logic        flush;
  logic        test_end;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        out_valid;
  logic        out_ready;
  logic        test_ending;
  logic        test_has_ended;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpu_nios_oci_dct_packer dut (
    .clk            (clk),
    .reset          (reset),
    .atom_valid     (atom_valid),
    .atom           (atom),
    .atom_ready     (atom_ready),
    .flush          (flush),
    .test_end       (test_end),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag, input logic [3:0] cnt, input logic [29:0] buf_exp);
    check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, ".count"}, {28'd0, dct_count}, {28'd0, cnt});
    check({tag, ".buffer"}, {2'd0, dct_buffer}, {2'd0, buf_exp});
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, ".count"}, {28'd0, dct_count}, 32'd0);
    check({tag, ".buffer"}, {2'd0, dct_buffer}, 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    atom_valid = 1'b0;
    atom       = 2'd0;
    flush      = 1'b0;
    test_end   = 1'b0;
    out_ready  = 1'b0;
    step();
    step();
    check_idle("reset");
    check("reset.atom_ready", {31'd0, atom_ready}, 32'd0);
    check("reset.test_ending", {31'd0, test_ending}, 32'd0);
    check("reset.test_has_ended", {31'd0, test_has_ended}, 32'd0);
    reset = 1'b0;
    step();
    check("run.atom_ready", {31'd0, atom_ready}, 32'd1);

    // 1: 15 atoms k%4; atoms 12..14 are 0,1,2 so the top field is 6'h24.
    out_ready = 1'b1;
    for (int k = 0; k < 15; k++) begin
      atom_valid = 1'b1;
      atom = 2'(k % 4);
      step();
      if (k == 13) check("t1.no_early_frame", {31'd0, out_valid}, 32'd0);
    end
    atom_valid = 1'b0;
    check_frame("t1", 4'd15, 30'h24E4E4E4);
    step();
    check_idle("t1.one_cycle");

    // 2: three 2'b11 atoms then flush.
    for (int k = 0; k < 3; k++) begin
      atom_valid = 1'b1;
      atom = 2'b11;
      step();
    end
    atom_valid = 1'b0;
    check("t2.no_frame_before_flush", {31'd0, out_valid}, 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_frame("t2", 4'd3, 30'h3F);
    step();
    check_idle("t2.after");

    // 3: back-pressure with 30 atoms offered.
    out_ready = 1'b0;
    for (int k = 0; k < 30; k++) begin
      atom_valid = 1'b1;
      atom = 2'(k % 4);
      if (atom_ready !== 1'b1) check("t3.accept", {31'd0, atom_ready}, 32'd1);
      step();
    end
    check("t3.ready_low_when_full", {31'd0, atom_ready}, 32'd0);
    check_frame("t3.f1", 4'd15, 30'h24E4E4E4);
    atom_valid = 1'b1;
    atom = 2'd0;
    step();
    step();
    atom_valid = 1'b0;
    check_frame("t3.f1_stable", 4'd15, 30'h24E4E4E4);
    out_ready = 1'b1;
    step();
    check_frame("t3.f2", 4'd15, 30'h13939393);
    check("t3.ready_back", {31'd0, atom_ready}, 32'd1);
    step();
    check_idle("t3.after");

    // 4: empty flush, then flush together with an accepted atom.
    flush = 1'b1;
    step();
    check_idle("t4.empty_flush");
    atom_valid = 1'b1;
    atom = 2'd2;
    step();
    flush = 1'b0;
    atom_valid = 1'b0;
    check_frame("t4.flush_with_atom", 4'd1, 30'h2);
    step();
    check_idle("t4.after");

    // 5: five atoms, then drain with the consumer stalled for 4 cycles.
    for (int k = 0; k < 5; k++) begin
      atom_valid = 1'b1;
      atom = 2'd1;
      step();
    end
    atom_valid = 1'b0;
    out_ready = 1'b0;
    test_end = 1'b1;
    step();
    test_end = 1'b0;
    check("t5.ending", {31'd0, test_ending}, 32'd1);
    check("t5.refuse", {31'd0, atom_ready}, 32'd0);
    for (int k = 0; k < 3; k++) step();
    check_frame("t5.frame", 4'd5, 30'h155);
    check("t5.still_ending", {31'd0, test_ending}, 32'd1);
    check("t5.not_ended", {31'd0, test_has_ended}, 32'd0);
    out_ready = 1'b1;
    step();
    check("t5.ended", {31'd0, test_has_ended}, 32'd1);
    check("t5.ending_off", {31'd0, test_ending}, 32'd0);
    check_idle("t5.after_handoff");
    atom_valid = 1'b1;
    flush = 1'b1;
    test_end = 1'b1;
    check("t5.refuse_later", {31'd0, atom_ready}, 32'd0);
    step();
    atom_valid = 1'b0;
    flush = 1'b0;
    test_end = 1'b0;
    step();
    check_idle("t5.ignored");
    check("t5.sticky", {31'd0, test_has_ended}, 32'd1);

    // 6: asynchronous reset with a held frame and 7 atoms in the accumulator.
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    out_ready = 1'b0;
    for (int k = 0; k < 22; k++) begin
      atom_valid = 1'b1;
      atom = 2'd3;
      step();
    end
    atom_valid = 1'b0;
    check_frame("t6.held", 4'd15, 30'h3FFFFFFF);
    #2;
    reset = 1'b1;
    #1;
    check_idle("t6.async_reset");
    check("t6.test_ending", {31'd0, test_ending}, 32'd0);
    check("t6.test_has_ended", {31'd0, test_has_ended}, 32'd0);
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 15; k++) begin
      atom_valid = 1'b1;
      atom = 2'd2;
      step();
    end
    atom_valid = 1'b0;
    check_frame("t6.fresh", 4'd15, 30'h2AAAAAAA);
    step();
    check_idle("t6.after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
